// File: rtl/gpio_pattern_gen_pkg.sv
// gpio_pattern_gen_pkg
// Shared definitions for the GPIO pattern generator: TX packet field
// positions, the generator FSM state type and a helper that turns a packet's
// hold field into the tick count actually loaded.
// Ports: none (package).

package gpio_pattern_gen_pkg;

  // TX FIFO word layout (29 bits): [28] config flag, [27:16] hold, [15:0] pins
  localparam int GPIO_PKT_WIDTH   = 29;
  localparam int GPIO_PKT_CFG_BIT = 28;
  localparam int GPIO_HOLD_MSB    = 27;
  localparam int GPIO_HOLD_LSB    = 16;
  localparam int GPIO_HOLD_WIDTH  = GPIO_HOLD_MSB - GPIO_HOLD_LSB + 1;

  typedef enum logic {
    PG_IDLE,
    PG_HOLD
  } gpio_pg_state_t;

  // A hold of zero would never expire cleanly, so it is treated as one tick.
  function automatic logic [GPIO_HOLD_WIDTH-1:0] holdLoadValue(
    input logic [GPIO_PKT_WIDTH-1:0] pkt
  );
    logic [GPIO_HOLD_WIDTH-1:0] hold;
    hold = pkt[GPIO_HOLD_MSB:GPIO_HOLD_LSB];
    return (hold == '0) ? GPIO_HOLD_WIDTH'(1) : hold;
  endfunction

endpackage

// File: rtl/gpio_pattern_gen_sample_tick_gen.sv
// sample_tick_gen
// Sample-rate prescaler. Counts 0..max_count_i and raises tick_o for one
// cycle when the count reaches (or exceeds) max_count_i, then restarts at 0.
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   clr_i        restart the count from 0 on the next edge
//   max_count_i  sample period minus 1, in clk cycles
//   tick_o       one-cycle sample tick (combinational from the count)

module sample_tick_gen #(
  parameter int RATE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [RATE_WIDTH-1:0] max_count_i,
  output logic                  tick_o
);

  logic [RATE_WIDTH-1:0] count_q;
  logic [RATE_WIDTH-1:0] count_d;

  // >= rather than == so that lowering max_count mid-run never forces the
  // counter to wrap all the way around before the next tick.
  always_comb begin
    tick_o  = (count_q >= max_count_i);
    count_d = count_q + RATE_WIDTH'(1);
    if (clr_i || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen
// Output-direction counterpart of the logic-analyzer capture path. Pops data
// packets from the peripheral TX FIFO (first-word-fall-through), drives each
// packet's pin values and holds them for the packet's number of sample ticks.
// Ports:
//   clk           system clock
//   rst           synchronous active-low reset
//   en            pattern enable
//   max_count     sample period minus 1, in clk cycles
//   dir_mask      1 = pin driven as output
//   tx_data       head word of the TX FIFO
//   tx_empty      TX FIFO empty
//   tx_rden       pop strobe (combinational)
//   out           registered pin values
//   tristate      registered ~dir_mask (1 = pin high-Z)
//   clr_underrun  clears the sticky underrun flag
//   underrun      sticky: FIFO ran dry while streaming
//   idle          generator idle and FIFO empty

import gpio_pattern_gen_pkg::*;

module gpio_pattern_gen #(
  parameter int PIN_WIDTH  = 16,
  parameter int HOLD_WIDTH = 12,
  parameter int RATE_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [RATE_WIDTH-1:0]     max_count,
  input  logic [PIN_WIDTH-1:0]      dir_mask,
  input  logic [GPIO_PKT_WIDTH-1:0] tx_data,
  input  logic                      tx_empty,
  output logic                      tx_rden,
  output logic [PIN_WIDTH-1:0]      out,
  output logic [PIN_WIDTH-1:0]      tristate,
  input  logic                      clr_underrun,
  output logic                      underrun,
  output logic                      idle
);

  gpio_pg_state_t         state_q, state_d;
  logic [PIN_WIDTH-1:0]   out_q, out_d;
  logic [PIN_WIDTH-1:0]   tristate_q;
  logic [HOLD_WIDTH-1:0]  remaining_q, remaining_d;
  logic                   underrun_q, underrun_d;
  logic                   validHead;
  logic                   underrunSet;
  logic                   load;
  logic                   tick;

  // The prescaler restarts on every pop so each packet's hold window is
  // measured from the cycle its pins appear.
  sample_tick_gen #(
    .RATE_WIDTH (RATE_WIDTH)
  ) uTickGen (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (tx_rden),
    .max_count_i (max_count),
    .tick_o      (tick)
  );

  // Next-state logic. A config packet at the head is never popped; it simply
  // stalls the generator in IDLE until the host side consumes it.
  always_comb begin
    validHead   = ~tx_empty & ~tx_data[GPIO_PKT_CFG_BIT];
    state_d     = state_q;
    out_d       = out_q;
    remaining_d = remaining_q;
    underrunSet = 1'b0;
    load        = 1'b0;

    case (state_q)
      PG_IDLE: begin
        if (en && validHead) begin
          load    = 1'b1;
          state_d = PG_HOLD;
        end
      end
      PG_HOLD: begin
        if (!en) begin
          state_d = PG_IDLE;
        end else if (tick) begin
          if (remaining_q > HOLD_WIDTH'(1)) begin
            remaining_d = remaining_q - HOLD_WIDTH'(1);
          end else if (validHead) begin
            // Reload on the expiring tick so back-to-back packets have no gap.
            load = 1'b1;
          end else begin
            state_d     = PG_IDLE;
            underrunSet = tx_empty;
          end
        end
      end
      default: begin
        state_d = PG_IDLE;
      end
    endcase

    if (load) begin
      out_d       = tx_data[PIN_WIDTH-1:0];
      remaining_d = holdLoadValue(tx_data);
    end

    // A new underrun outranks a simultaneous clear so no event is lost.
    underrun_d = underrunSet | (underrun_q & ~clr_underrun);
  end

  assign tx_rden  = load & rst;
  assign out      = out_q;
  assign tristate = tristate_q;
  assign underrun = underrun_q;
  assign idle     = (state_q == PG_IDLE) & tx_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= PG_IDLE;
      out_q       <= '0;
      tristate_q  <= '1;
      remaining_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      tristate_q  <= ~dir_mask;
      remaining_q <= remaining_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// tb_gpio_pattern_gen
// Directed bench for gpio_pattern_gen. A small array-based FWFT FIFO model
// feeds tx_data/tx_empty; each step compares DUT outputs against
// hand-computed values.

module tb_gpio_pattern_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] max_count;
  logic [15:0] dir_mask;
  logic [28:0] tx_data;
  logic        tx_empty;
  logic        tx_rden;
  logic [15:0] out;
  logic [15:0] tristate;
  logic        clr_underrun;
  logic        underrun;
  logic        idle;

  logic [28:0] fifoMem [0:15];
  logic [7:0]  rdPtr;
  logic [7:0]  wrPtr;
  logic        fifoFlush;
  int          popCount;
  int          vectors;
  int          miscompares;
  int          popBase;

  gpio_pattern_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .max_count    (max_count),
    .dir_mask     (dir_mask),
    .tx_data      (tx_data),
    .tx_empty     (tx_empty),
    .tx_rden      (tx_rden),
    .out          (out),
    .tristate     (tristate),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_data  = fifoMem[rdPtr[3:0]];
  assign tx_empty = (rdPtr == wrPtr);

  // FIFO read side: pop on tx_rden, or drop everything on a bench flush.
  always @(posedge clk) begin
    if (fifoFlush) begin
      rdPtr <= wrPtr;
    end else if (tx_rden) begin
      rdPtr    <= rdPtr + 8'd1;
      popCount <= popCount + 1;
    end
  end

  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] hold, input logic [15:0] pins);
    fifoMem[wrPtr[3:0]] = {1'b0, hold, pins};
    wrPtr = wrPtr + 8'd1;
  endtask

  task automatic pushConfig(input logic [27:0] body);
    fifoMem[wrPtr[3:0]] = {1'b1, body};
    wrPtr = wrPtr + 8'd1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [15:0] b2bExp [0:4];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    popCount     = 0;
    rdPtr        = 8'd0;
    wrPtr        = 8'd0;
    fifoFlush    = 1'b0;
    rst          = 1'b0;
    en           = 1'b0;
    max_count    = 24'd0;
    dir_mask     = 16'h0000;
    clr_underrun = 1'b0;
    for (int i = 0; i < 16; i++) fifoMem[i] = '0;

    // Reset values
    stepClk(3);
    checkOutput("rst_out", 32'(out), 32'h0);
    checkOutput("rst_tristate", 32'(tristate), 32'hFFFF);
    checkOutput("rst_rden", 32'(tx_rden), 32'h0);
    checkOutput("rst_idle", 32'(idle), 32'h1);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);

    rst      = 1'b1;
    dir_mask = 16'h00FF;
    stepClk(1);
    checkOutput("tristate_mask", 32'(tristate), 32'hFF00);

    // Single packet, max_count=3, hold=2 -> 8 clocks then underrun
    $display("[TB] single packet");
    max_count = 24'd3;
    applyStimulus(12'd2, 16'hA5A5);
    en = 1'b1;
    #1;
    checkOutput("single_rden", 32'(tx_rden), 32'h1);
    checkOutput("single_out_before", 32'(out), 32'h0);
    stepClk(1);
    checkOutput("single_out_load", 32'(out), 32'hA5A5);
    checkOutput("single_pop", 32'(popCount), 32'd1);
    checkOutput("single_rden_after", 32'(tx_rden), 32'h0);
    for (int i = 1; i < 8; i++) begin
      stepClk(1);
      checkOutput("single_hold_out", 32'(out), 32'hA5A5);
      checkOutput("single_hold_underrun", 32'(underrun), 32'h0);
    end
    stepClk(1);
    checkOutput("single_underrun", 32'(underrun), 32'h1);
    checkOutput("single_idle", 32'(idle), 32'h1);
    checkOutput("single_out_kept", 32'(out), 32'hA5A5);

    clr_underrun = 1'b1;
    stepClk(1);
    clr_underrun = 1'b0;
    checkOutput("clr_underrun", 32'(underrun), 32'h0);

    // Back-to-back, tick every clock: 1,2,2,2,4 then underrun
    $display("[TB] back-to-back");
    max_count = 24'd0;
    popBase   = popCount;
    b2bExp[0] = 16'h0001;
    b2bExp[1] = 16'h0002;
    b2bExp[2] = 16'h0002;
    b2bExp[3] = 16'h0002;
    b2bExp[4] = 16'h0004;
    applyStimulus(12'd1, 16'h0001);
    applyStimulus(12'd3, 16'h0002);
    applyStimulus(12'd0, 16'h0004);
    #1;
    for (int i = 0; i < 5; i++) begin
      stepClk(1);
      checkOutput("b2b_out", 32'(out), 32'(b2bExp[i]));
    end
    checkOutput("b2b_pops", 32'(popCount), 32'(popBase + 3));
    // Underrun is being set this cycle; a simultaneous clear must lose
    clr_underrun = 1'b1;
    stepClk(1);
    clr_underrun = 1'b0;
    checkOutput("set_wins_clear", 32'(underrun), 32'h1);
    clr_underrun = 1'b1;
    stepClk(1);
    clr_underrun = 1'b0;
    checkOutput("clr_after_set", 32'(underrun), 32'h0);

    // Config word at head: data held 4 clocks, config never popped
    $display("[TB] config at head");
    max_count = 24'd1;
    popBase   = popCount;
    applyStimulus(12'd2, 16'h00F0);
    pushConfig(28'h8000000);
    #1;
    checkOutput("cfg_data_rden", 32'(tx_rden), 32'h1);
    stepClk(1);
    checkOutput("cfg_out_load", 32'(out), 32'h00F0);
    stepClk(3);
    checkOutput("cfg_no_pop_rden", 32'(tx_rden), 32'h0);
    checkOutput("cfg_out_held", 32'(out), 32'h00F0);
    stepClk(1);
    checkOutput("cfg_no_underrun", 32'(underrun), 32'h0);
    checkOutput("cfg_pops", 32'(popCount), 32'(popBase + 1));
    checkOutput("cfg_rden_stall", 32'(tx_rden), 32'h0);
    fifoFlush = 1'b1;
    stepClk(1);
    fifoFlush = 1'b0;
    checkOutput("cfg_idle", 32'(idle), 32'h1);

    // Disable mid-hold, then re-enable
    $display("[TB] disable mid-hold");
    max_count = 24'd0;
    popBase   = popCount;
    applyStimulus(12'd100, 16'h1234);
    applyStimulus(12'd1, 16'h5678);
    #1;
    stepClk(1);
    checkOutput("dis_out_load", 32'(out), 32'h1234);
    stepClk(9);
    en = 1'b0;
    stepClk(1);
    checkOutput("dis_out_kept", 32'(out), 32'h1234);
    checkOutput("dis_rden", 32'(tx_rden), 32'h0);
    stepClk(4);
    checkOutput("dis_pops", 32'(popCount), 32'(popBase + 1));
    checkOutput("dis_out_still", 32'(out), 32'h1234);
    en = 1'b1;
    #1;
    checkOutput("reen_rden", 32'(tx_rden), 32'h1);
    stepClk(1);
    checkOutput("reen_out", 32'(out), 32'h5678);
    stepClk(1);
    checkOutput("reen_underrun", 32'(underrun), 32'h1);
    clr_underrun = 1'b1;
    stepClk(1);
    clr_underrun = 1'b0;
    checkOutput("reen_clr", 32'(underrun), 32'h0);

    // Reset while holding a packet
    $display("[TB] reset mid-hold");
    applyStimulus(12'd50, 16'hBEEF);
    #1;
    stepClk(3);
    checkOutput("rsthold_out", 32'(out), 32'hBEEF);
    rst = 1'b0;
    #1;
    checkOutput("rsthold_rden", 32'(tx_rden), 32'h0);
    stepClk(1);
    checkOutput("rsthold_out_clr", 32'(out), 32'h0);
    checkOutput("rsthold_tristate", 32'(tristate), 32'hFFFF);
    checkOutput("rsthold_idle", 32'(idle), 32'h1);
    rst = 1'b1;
    stepClk(2);
    checkOutput("rsthold_stay_idle", 32'(idle), 32'h1);
    checkOutput("rsthold_out_stays", 32'(out), 32'h0);
    checkOutput("rsthold_tristate_mask", 32'(tristate), 32'hFF00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_gen.md
Name: gpio_pattern_gen

Overview:
- Output-direction counterpart of the GPIO logic-analyzer capture path.
- Pops host data packets from the peripheral TX FIFO, drives each packet's 16 pin values on `out`, and holds them for a packet-specified number of sample ticks.
- The sample tick rate comes from the same sample-rate config register as capture.
- Sits inside the GPIO peripheral wrapper beside the capture logic and `generic_config_regs`.

Parameters:
- pin_width, 16, number of driven pins.
- hold_width, 12, width of per-packet hold count field.
- rate_width, 24, width of prescaler max_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- en  in  1  pattern enable (config ENABLE bit).
- max_count  in  rate_width  sample period minus 1, in clk cycles.
- dir_mask  in  pin_width  1 = pin driven as output.
- tx_data  in  usb_packet_width-periph_address_width (29)  FWFT head of TX FIFO.
- tx_empty  in  1  TX FIFO empty.
- tx_rden  out  1  pop strobe; combinational.
- out  out  pin_width  registered pin values.
- tristate  out  pin_width  1 = pin high-Z; registered ~dir_mask.
- clr_underrun  in  1  clears the sticky underrun flag.
- underrun  out  1  sticky: FIFO ran dry while streaming.
- idle  out  1  state IDLE and tx_empty.

Behaviour:
- Packet format:
  - [28]=0 marks a data packet.
  - [27:16] = hold (number of ticks); hold=0 is treated as 1.
  - [15:0] = pin values.
  - [28]=1 is a config packet. This block never pops it and stalls while it is at the head.
- Reset (rst=0): out=0, tristate=all 1, underrun=0, state=IDLE, prescaler=0, remaining=0, tx_rden=0.
- Prescaler: counts 0..max_count and raises one-cycle `tick` when count >= max_count, then returns to 0. Using >= means a mid-run decrease of max_count takes effect with no long wrap. The prescaler is cleared on every packet load.
- `valid_head` = ~tx_empty & ~tx_data[28].
- IDLE state:
  - If en & valid_head: assert tx_rden this cycle.
  - On the next edge: out <= tx_data[15:0], remaining <= max(hold,1), go to HOLD.
  - Latency from FIFO non-empty to pin change: 1 clk.
- HOLD state, on tick:
  - If remaining>1: remaining--.
  - If remaining==1 and en & valid_head: pop and load the next packet in the same cycle. No gap cycle, so consecutive packets are tick-aligned.
  - If remaining==1 and en & tx_empty: underrun<=1, go IDLE.
  - If remaining==1 and the head is a config packet: go IDLE (not an underrun).
- en=0 in any state: go IDLE next edge, no pops, out retains its last value.
- en rising with data already queued: load on the first cycle en=1.
- underrun: set as above; cleared when clr_underrun=1. If set and clear fire in the same cycle, set wins.
- tristate <= ~dir_mask every cycle (1-cycle registered), independent of state.
- tx_rden is never asserted when tx_empty=1 or tx_data[28]=1.
- Reset mid-HOLD: all state returns to reset values on that edge; the popped packet is discarded.

Decomposition:
- lycan_globals gets:
  - Packet field constants: GPIO_PKT_CFG_BIT=28, GPIO_HOLD_MSB=27, GPIO_HOLD_LSB=16.
  - typedef enum gpio_pg_state_t {PG_IDLE, PG_HOLD}.
- One sub-module: sample_tick_gen (prescaler with clear input and >= compare). It can later be shared with la_top.

Test Plan:
- Reset: rst=0 for 3 clks -> out=0, tristate=16'hFFFF, tx_rden=0, idle=1 (FIFO empty).
- Single packet: max_count=3, push {0,12'd2,16'hA5A5}, en=1 -> tx_rden one cycle, out=A5A5 one clk later, held 8 clks, then underrun=1 and state IDLE.
- Back-to-back: max_count=0, packets 0x0001/hold1, 0x0002/hold3, 0x0004/hold0 -> out sequence 1,2,2,2,4 on consecutive clks with no gaps.
- Config at head: data(hold 2) then {1,28'h8000000} with max_count=1 -> data is held 4 clks, tx_rden never asserted for the config word, underrun stays 0.
- Disable mid-hold: hold=100, drop en after 10 clks -> IDLE next edge, out unchanged, no further pops. Re-enable -> next packet loads in 1 clk.
- Underrun clear: with underrun=1, pulse clr_underrun -> underrun=0. Assert clr_underrun in the same cycle underrun is being set -> underrun=1.
